pe_conv_scheduler: RTL and testbench
====================================

# pe_conv_scheduler

Sequencer that drives a single PE through a full 3x3 valid-convolution layer. It walks output pixels filter-by-filter, row-by-row, and issues IFM/weight buffer reads so one operand pair reaches the PE per cycle. It frames each 27-MAC window with `pe_en`/`pe_finish` pulses and captures the PE result into the OFM buffer. It sits between the on-chip IFM/weight/OFM buffers and the PE.

## Interface
- `IFM_W`, 32: input width in pixels
- `IFM_H`, 32: input height in pixels
- `CH`, 3: input channels
- `K`, 3: kernel size (KxK)
- `FILTERS`, 3: output filters
- `DW`, 8: data width
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  one-cycle pulse that begins a layer; ignored while `busy`=1
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last OFM write
- `ifm_rd_en`  out  1  IFM buffer read strobe
- `ifm_addr`  out  clog2(IFM_W*IFM_H*CH)  IFM read address
- `w_rd_en`  out  1  weight buffer read strobe; always equal to `ifm_rd_en`
- `w_addr`  out  clog2(K*K*CH*FILTERS)  weight read address
- `pe_en`  out  1  PE accumulator start pulse
- `pe_finish`  out  1  PE window-end pulse
- `pe_valid`  in  1  PE result valid
- `pe_ofm`  in  DW  PE result
- `ofm_wr_en`  out  1  OFM buffer write strobe
- `ofm_addr`  out  clog2(OH*OW*FILTERS)  OFM write address; OH=IFM_H-K+1, OW=IFM_W-K+1
- `ofm_data`  out  DW  registered copy of `pe_ofm`

## Operation
- **Reset:** all outputs are 0 and the FSM is in IDLE. `rst` asserted in any state aborts the layer; outputs are 0 on the next cycle and no `done` is produced.
- **Loop order:** outer to inner is f, oy, ox, then the window loop c, ky, kx.
- **Read addresses:**
  - `ifm_addr` = c*IFM_H*IFM_W + (oy+ky)*IFM_W + (ox+kx)
  - `w_addr` = f*CH*K*K + c*K*K + ky*K + kx
- **OFM address:** `ofm_addr` = f*OH*OW + oy*OW + ox.
- **FSM states:**
  - IDLE: on `start`, go to READ. `busy` rises the next cycle.
  - READ: assert the read strobes for exactly CH*K*K consecutive cycles, one (c,ky,kx) per cycle. After the last read, go to FIN.
  - FIN: pulse `pe_finish` for one cycle, then go to WAIT.
  - WAIT: hold until `pe_valid`=1. On that cycle, register `pe_ofm` into `ofm_data`, then go to WRITE.
  - WRITE: assert `ofm_wr_en` for one cycle with `ofm_addr`.
    - If (f,oy,ox) is the last pixel, go to DONE.
    - Otherwise advance ox, wrapping ox to 0 and incrementing oy, then wrapping oy to 0 and incrementing f, and go to READ.
  - DONE: pulse `done` for one cycle, drop `busy`, go to IDLE.
- **`pe_en` timing:** the buffers have 1-cycle read latency, so `pe_en` is a one-cycle pulse on the cycle after the first read of each window, aligned with the first operand pair at the PE.
- **`pe_valid` outside WAIT:** ignored; no write.
- **`start` outside IDLE:** ignored, including a `start` in the same cycle as `done`.
- **Width rule:** all counters are unsigned and sized by clog2 of their bound. Address arithmetic is computed at full width before truncation to the port width; there is no overflow for legal parameters.

## Timing
- Let t0 be the first READ cycle of a window.
- Reads occur in t0..t0+26, one operand pair per cycle with no gaps.
- `pe_en` is high at t0+1. Operands are presented at t0+1..t0+27.
- `pe_finish` is high at t0+28, so the pen-to-pfinish spacing is 27 cycles.
- If `pe_valid` arrives at t0+28+L, `ofm_wr_en` is high at t0+29+L and the next window's READ starts at t0+30+L.
- `done` is high one cycle after the final `ofm_wr_en`.
- `busy` is high from the cycle after the accepted `start` through the `done` cycle.

## Structure
- Shared package `pe_sched_pkg`:
  - FSM state enum (IDLE, READ, FIN, WAIT, WRITE, DONE)
  - localparam functions for OH, OW and the address widths
- Sub-module `conv_window_cnt`: nested kx/ky/c counter.
  - Inputs: `clk`, `rst`, `clr`, `inc`.
  - Outputs: `kx`, `ky`, `c`, `last`.
  - Instantiated once.
- The pixel/filter counters and address multiply-adds live in the top.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `start`=1. Require all outputs 0 and `busy`=0.
- **First window, defaults:**
  - Pulse `start`. Require `ifm_addr` sequence 0,1,2,32,33,34,64,65,66,1024,1025,… with the last read at 2114.
  - Require `w_addr` 0..26.
  - Require `pe_en` exactly 1 cycle after the first read and `pe_finish` 28 cycles after it.
- **Result capture:**
  - Drive a PE model returning `pe_valid` 3 cycles after `pe_finish` with `pe_ofm`=0x5A.
  - Require `ofm_wr_en`=1, `ofm_addr`=0, `ofm_data`=0x5A one cycle later, and the next READ starting 1 cycle after that.
- **Row wrap:** require the first `ifm_addr` of pixel 30 (ox=0, oy=1) to be 32 and its `ofm_addr` to be 30.
- **Layer end:**
  - With IFM_W=IFM_H=4, CH=1, FILTERS=2, require 8 OFM writes at addresses 0..7.
  - Require the last `w_addr` to be 17.
  - Require `done` to pulse once, then `busy`=0.
- **Robustness:**
  - A `start` pulse during READ is ignored and the address sequence is unchanged.
  - `rst` at READ cycle 10 zeroes all outputs next cycle. A new `start` restarts at `ifm_addr`=0, `w_addr`=0.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared types and size helpers for the single-PE convolution scheduler.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StFin,
    StWait,
    StWrite,
    StDone
  } sched_state_e;

  // Output extent of a valid (unpadded) convolution along one axis.
  function automatic int unsigned out_dim(int unsigned n, int unsigned k);
    return n - k + 1;
  endfunction

  // Counter/address width for a bound of n; never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_cnt.sv
// Nested kx -> ky -> c counter that walks one CH*K*K convolution window.
module conv_window_cnt import pe_sched_pkg::*; #(
  parameter int unsigned K  = 3,
  parameter int unsigned CH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [cnt_w(K)-1:0]     kx,
  output logic [cnt_w(K)-1:0]     ky,
  output logic [cnt_w(CH)-1:0]    c,
  output logic                    last
);

  localparam int unsigned KW = cnt_w(K);
  localparam int unsigned CW = cnt_w(CH);

  logic [KW-1:0] kx_q, ky_q;
  logic [CW-1:0] c_q;
  logic          kx_wrap, ky_wrap, c_wrap;

  assign kx_wrap = (kx_q == KW'(K - 1));
  assign ky_wrap = (ky_q == KW'(K - 1));
  assign c_wrap  = (c_q == CW'(CH - 1));

  // Wraps to all-zero after the final position, ready for the next window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      kx_q <= '0;
      ky_q <= '0;
      c_q  <= '0;
    end else if (inc) begin
      if (kx_wrap) begin
        kx_q <= '0;
        if (ky_wrap) begin
          ky_q <= '0;
          c_q  <= c_wrap ? '0 : c_q + 1'b1;
        end else begin
          ky_q <= ky_q + 1'b1;
        end
      end else begin
        kx_q <= kx_q + 1'b1;
      end
    end
  end

  assign kx   = kx_q;
  assign ky   = ky_q;
  assign c    = c_q;
  assign last = kx_wrap && ky_wrap && c_wrap;

endmodule

// File: rtl/pe_conv_scheduler.sv
// Drives one PE through a full KxK valid-convolution layer: buffer reads, PE framing, OFM writes.
module pe_conv_scheduler import pe_sched_pkg::*; #(
  parameter int unsigned IFM_W   = 32,
  parameter int unsigned IFM_H   = 32,
  parameter int unsigned CH      = 3,
  parameter int unsigned K       = 3,
  parameter int unsigned FILTERS = 3,
  parameter int unsigned DW      = 8,
  localparam int unsigned OH     = out_dim(IFM_H, K),
  localparam int unsigned OW     = out_dim(IFM_W, K),
  localparam int unsigned IFM_AW = cnt_w(IFM_W * IFM_H * CH),
  localparam int unsigned W_AW   = cnt_w(K * K * CH * FILTERS),
  localparam int unsigned OFM_AW = cnt_w(OH * OW * FILTERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [IFM_AW-1:0] ifm_addr,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_addr,
  output logic              pe_en,
  output logic              pe_finish,
  input  logic              pe_valid,
  input  logic [DW-1:0]     pe_ofm,
  output logic              ofm_wr_en,
  output logic [OFM_AW-1:0] ofm_addr,
  output logic [DW-1:0]     ofm_data
);

  localparam int unsigned KW  = cnt_w(K);
  localparam int unsigned CW  = cnt_w(CH);
  localparam int unsigned OXW = cnt_w(OW);
  localparam int unsigned OYW = cnt_w(OH);
  localparam int unsigned FW  = cnt_w(FILTERS);

  sched_state_e state_q, state_d;

  logic [OXW-1:0] ox_q;
  logic [OYW-1:0] oy_q;
  logic [FW-1:0]  f_q;
  logic [KW-1:0]  kx, ky;
  logic [CW-1:0]  c;
  logic           win_last, win_first, pix_last;
  logic           pe_en_q, pe_finish_q;
  logic [DW-1:0]  ofm_data_q;

  conv_window_cnt #(
    .K  (K),
    .CH (CH)
  ) u_win_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!ifm_rd_en),
    .inc  (ifm_rd_en),
    .kx   (kx),
    .ky   (ky),
    .c    (c),
    .last (win_last)
  );

  assign win_first = (c == '0) && (ky == '0) && (kx == '0);
  assign pix_last  = (f_q == FW'(FILTERS - 1)) && (oy_q == OYW'(OH - 1)) &&
                     (ox_q == OXW'(OW - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (win_last) state_d = StFin;
      StFin:   state_d = StWait;
      StWait:  if (pe_valid) state_d = StWrite;
      StWrite: state_d = pix_last ? StDone : StRead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ox_q        <= '0;
      oy_q        <= '0;
      f_q         <= '0;
      pe_en_q     <= 1'b0;
      pe_finish_q <= 1'b0;
      ofm_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      // One-cycle buffer latency: PE strobes trail the read that starts/ends a window.
      pe_en_q     <= ifm_rd_en && win_first;
      pe_finish_q <= (state_q == StFin);
      if (state_q == StWait && pe_valid) begin
        ofm_data_q <= pe_ofm;
      end
      if (state_q == StIdle) begin
        ox_q <= '0;
        oy_q <= '0;
        f_q  <= '0;
      end else if (state_q == StWrite && !pix_last) begin
        if (ox_q == OXW'(OW - 1)) begin
          ox_q <= '0;
          if (oy_q == OYW'(OH - 1)) begin
            oy_q <= '0;
            f_q  <= f_q + 1'b1;
          end else begin
            oy_q <= oy_q + 1'b1;
          end
        end else begin
          ox_q <= ox_q + 1'b1;
        end
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign ifm_rd_en = (state_q == StRead);
  assign w_rd_en   = ifm_rd_en;
  assign ofm_wr_en = (state_q == StWrite);
  assign pe_en     = pe_en_q;
  assign pe_finish = pe_finish_q;
  assign ofm_data  = ofm_data_q;

  // Addresses are formed at 32 bits and cut to port width; held at zero when not strobed.
  assign ifm_addr = ifm_rd_en ?
      IFM_AW'(32'(c) * (IFM_H * IFM_W) + (32'(oy_q) + 32'(ky)) * IFM_W +
              32'(ox_q) + 32'(kx)) : '0;
  assign w_addr = ifm_rd_en ?
      W_AW'(32'(f_q) * (CH * K * K) + 32'(c) * (K * K) + 32'(ky) * K + 32'(kx)) : '0;
  assign ofm_addr = ofm_wr_en ?
      OFM_AW'(32'(f_q) * (OH * OW) + 32'(oy_q) * OW + 32'(ox_q)) : '0;

endmodule

// File: tb/tb_pe_conv_scheduler.sv
// Self-checking bench: default 32x32x3 layer (first windows, abort) and a small 4x4x1 full layer.
module tb_pe_conv_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Default-parameter DUT
  logic        d0_rst = 1'b1, d0_start = 1'b0, d0_pv = 1'b0;
  logic [7:0]  d0_ofm = '0;
  logic        d0_busy, d0_done, d0_rd, d0_wrd, d0_pe_en, d0_pfin, d0_wr;
  logic [11:0] d0_ifm_addr, d0_ofm_addr;
  logic [6:0]  d0_w_addr;
  logic [7:0]  d0_data;

  pe_conv_scheduler u_d0 (
    .clk       (clk),
    .rst       (d0_rst),
    .start     (d0_start),
    .busy      (d0_busy),
    .done      (d0_done),
    .ifm_rd_en (d0_rd),
    .ifm_addr  (d0_ifm_addr),
    .w_rd_en   (d0_wrd),
    .w_addr    (d0_w_addr),
    .pe_en     (d0_pe_en),
    .pe_finish (d0_pfin),
    .pe_valid  (d0_pv),
    .pe_ofm    (d0_ofm),
    .ofm_wr_en (d0_wr),
    .ofm_addr  (d0_ofm_addr),
    .ofm_data  (d0_data)
  );

  // Small DUT: 4x4 input, 1 channel, 2 filters -> 2x2x2 output
  logic        d1_rst = 1'b1, d1_start = 1'b0, d1_pv = 1'b0;
  logic [7:0]  d1_ofm = '0;
  logic        d1_busy, d1_done, d1_rd, d1_wrd, d1_pe_en, d1_pfin, d1_wr;
  logic [3:0]  d1_ifm_addr;
  logic [4:0]  d1_w_addr;
  logic [2:0]  d1_ofm_addr;
  logic [7:0]  d1_data;

  pe_conv_scheduler #(
    .IFM_W   (4),
    .IFM_H   (4),
    .CH      (1),
    .K       (3),
    .FILTERS (2),
    .DW      (8)
  ) u_d1 (
    .clk       (clk),
    .rst       (d1_rst),
    .start     (d1_start),
    .busy      (d1_busy),
    .done      (d1_done),
    .ifm_rd_en (d1_rd),
    .ifm_addr  (d1_ifm_addr),
    .w_rd_en   (d1_wrd),
    .w_addr    (d1_w_addr),
    .pe_en     (d1_pe_en),
    .pe_finish (d1_pfin),
    .pe_valid  (d1_pv),
    .pe_ofm    (d1_ofm),
    .ofm_wr_en (d1_wr),
    .ofm_addr  (d1_ofm_addr),
    .ofm_data  (d1_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic d0_all_zero(input string tag);
    chk({tag, "_busy"}, d0_busy, 0);
    chk({tag, "_rd"}, d0_rd, 0);
    chk({tag, "_wrd"}, d0_wrd, 0);
    chk({tag, "_ifm_addr"}, d0_ifm_addr, 0);
    chk({tag, "_w_addr"}, d0_w_addr, 0);
    chk({tag, "_pe_en"}, d0_pe_en, 0);
    chk({tag, "_pe_finish"}, d0_pfin, 0);
    chk({tag, "_wr"}, d0_wr, 0);
    chk({tag, "_ofm_addr"}, d0_ofm_addr, 0);
    chk({tag, "_ofm_data"}, d0_data, 0);
    chk({tag, "_done"}, d0_done, 0);
  endtask

  // One full window on the default DUT, checked against the loop-nest address formulas.
  task automatic d0_window(input int px, input int lat, input logic [7:0] val, input int inj,
                           output int first_ifm, output int wr_addr);
    int f, oy, ox, n;
    f  = px / 900;
    oy = (px / 30) % 30;
    ox = px % 30;
    n  = 0;
    while (d0_rd !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("d0_first_read", d0_rd, 1);
    first_ifm = int'(d0_ifm_addr);
    for (int i = 0; i < 27; i++) begin
      int c, ky, kx;
      c  = i / 9;
      ky = (i / 3) % 3;
      kx = i % 3;
      chk("d0_rd_en", d0_rd, 1);
      chk("d0_w_rd_en", d0_wrd, 1);
      chk("d0_ifm_addr", d0_ifm_addr, c * 1024 + (oy + ky) * 32 + ox + kx);
      chk("d0_w_addr", d0_w_addr, f * 27 + i);
      chk("d0_pe_en", d0_pe_en, (i == 1));
      chk("d0_busy", d0_busy, 1);
      d0_start = (i == inj);
      d0_pv    = ($urandom_range(0, 3) == 0);
      d0_ofm   = ~val;
      tick();
    end
    d0_start = 1'b0;
    chk("d0_fin_rd", d0_rd, 0);
    chk("d0_fin_early", d0_pfin, 0);
    d0_pv = ($urandom_range(0, 3) == 0);
    tick();
    chk("d0_pe_finish", d0_pfin, 1);
    chk("d0_pe_en_off", d0_pe_en, 0);
    for (int j = 0; j < lat; j++) begin
      d0_pv = 1'b0;
      tick();
      chk("d0_wait_wr", d0_wr, 0);
      chk("d0_wait_fin", d0_pfin, 0);
    end
    d0_pv  = 1'b1;
    d0_ofm = val;
    tick();
    d0_pv  = 1'b0;
    d0_ofm = ~val;
    chk("d0_ofm_wr_en", d0_wr, 1);
    chk("d0_ofm_addr", d0_ofm_addr, px);
    chk("d0_ofm_data", d0_data, val);
    chk("d0_wr_done", d0_done, 0);
    wr_addr = int'(d0_ofm_addr);
    tick();
    chk("d0_next_read", d0_rd, 1);
  endtask

  typedef struct {
    logic rst;
    logic start;
    logic busy;
    logic rd;
    int   ifm;
    int   w;
    logic pe_en;
  } vec_t;

  vec_t vecs[10];
  int   ifm_q[$], w_q[$], wr_q[$];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fi, wa, t_first, pend, reads, writes, dones, last_w, cyc;
    logic [7:0] exp_data;
    logic exp_wr, prev_last_wr, seen_done;

    // Reset held with start asserted, then first reads of window 0 with a stray start.
    vecs[0] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 1, 1, 1, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 1, 1, 1};
    vecs[5] = '{0, 0, 1, 1, 2, 2, 0};
    vecs[6] = '{0, 0, 1, 1, 32, 3, 0};
    vecs[7] = '{0, 1, 1, 1, 33, 4, 0};
    vecs[8] = '{0, 0, 1, 1, 34, 5, 0};
    vecs[9] = '{0, 0, 1, 1, 64, 6, 0};
    for (int v = 0; v < 10; v++) begin
      d0_rst   = vecs[v].rst;
      d0_start = vecs[v].start;
      tick();
      chk("vec_busy", d0_busy, vecs[v].busy);
      chk("vec_rd", d0_rd, vecs[v].rd);
      chk("vec_wrd", d0_wrd, vecs[v].rd);
      chk("vec_ifm_addr", d0_ifm_addr, vecs[v].ifm);
      chk("vec_w_addr", d0_w_addr, vecs[v].w);
      chk("vec_pe_en", d0_pe_en, vecs[v].pe_en);
      chk("vec_pe_finish", d0_pfin, 0);
      chk("vec_wr", d0_wr, 0);
      chk("vec_ofm_data", d0_data, 0);
      chk("vec_done", d0_done, 0);
    end

    // Fresh layer: capture at latency 3, then random latencies up to the row wrap.
    d0_rst   = 1'b1;
    d0_start = 1'b0;
    tick();
    tick();
    d0_all_zero("d0_reset");
    d0_rst   = 1'b0;
    d0_start = 1'b1;
    tick();
    d0_start = 1'b0;
    d0_window(0, 3, 8'h5A, 5, fi, wa);
    for (int px = 1; px <= 30; px++) begin
      d0_window(px, $urandom_range(0, 4), 8'($urandom), -1, fi, wa);
    end
    chk("row_wrap_ifm", fi, 32);
    chk("row_wrap_ofm", wa, 30);

    // Abort at READ cycle 10 of pixel 31, then restart from the beginning.
    for (int i = 0; i < 10; i++) tick();
    chk("abort_in_read", d0_rd, 1);
    d0_rst = 1'b1;
    tick();
    d0_all_zero("d0_abort");
    d0_rst = 1'b0;
    tick();
    chk("abort_idle_busy", d0_busy, 0);
    chk("abort_no_done", d0_done, 0);
    d0_start = 1'b1;
    tick();
    d0_start = 1'b0;
    chk("restart_rd", d0_rd, 1);
    chk("restart_ifm", d0_ifm_addr, 0);
    chk("restart_w", d0_w_addr, 0);
    d0_window(0, 1, 8'($urandom), -1, fi, wa);
    chk("restart_ofm_addr", wa, 0);

    // Small layer against a queue-based reference of the whole loop nest.
    d0_rst = 1'b1;
    tick();
    d1_rst = 1'b0;
    tick();
    for (int f = 0; f < 2; f++)
      for (int oy = 0; oy < 2; oy++)
        for (int ox = 0; ox < 2; ox++) begin
          wr_q.push_back(f * 4 + oy * 2 + ox);
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              ifm_q.push_back((oy + ky) * 4 + ox + kx);
              w_q.push_back(f * 9 + ky * 3 + kx);
            end
        end
    chk("d1_idle_busy", d1_busy, 0);
    d1_start = 1'b1;
    tick();
    d1_start     = 1'b0;
    t_first      = -100;
    pend         = -1;
    reads        = 0;
    writes       = 0;
    dones        = 0;
    last_w       = -1;
    exp_data     = '0;
    exp_wr       = 1'b0;
    prev_last_wr = 1'b0;
    seen_done    = 1'b0;
    for (cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
      chk("d1_busy", d1_busy, 1);
      if (d1_rd) begin
        if (reads % 9 == 0) t_first = cyc;
        if (ifm_q.size() == 0) begin
          chk("d1_extra_read", d1_rd, 0);
        end else begin
          chk("d1_ifm_addr", d1_ifm_addr, ifm_q.pop_front());
          chk("d1_w_addr", d1_w_addr, w_q.pop_front());
        end
        last_w = int'(d1_w_addr);
        reads++;
      end
      chk("d1_w_rd_en", d1_wrd, (reads > 0 && t_first >= 0 && cyc - t_first < 9));
      chk("d1_pe_en", d1_pe_en, (cyc == t_first + 1));
      chk("d1_pe_finish", d1_pfin, (cyc == t_first + 10));
      chk("d1_wr_timing", d1_wr, exp_wr);
      chk("d1_done", d1_done, prev_last_wr);
      prev_last_wr = 1'b0;
      if (d1_wr) begin
        if (wr_q.size() == 0) begin
          chk("d1_extra_write", d1_wr, 0);
        end else begin
          chk("d1_ofm_addr", d1_ofm_addr, wr_q.pop_front());
          chk("d1_ofm_data", d1_data, exp_data);
        end
        writes++;
        prev_last_wr = (writes == 8);
      end
      if (d1_done) begin
        dones++;
        seen_done = 1'b1;
      end
      // PE model: answer each pe_finish after 0..4 cycles; stray valids while idle.
      exp_wr = 1'b0;
      if (d1_pfin) pend = $urandom_range(0, 4);
      if (pend == 0) begin
        exp_data = 8'($urandom);
        d1_pv    = 1'b1;
        d1_ofm   = exp_data;
        exp_wr   = 1'b1;
        pend     = -1;
      end else if (pend > 0) begin
        pend--;
        d1_pv = 1'b0;
      end else begin
        d1_pv  = ($urandom_range(0, 2) == 0);
        d1_ofm = ~exp_data;
      end
      d1_start = d1_done ? 1'b1 : (d1_busy && $urandom_range(0, 5) == 0);
      tick();
    end
    d1_start = 1'b0;
    d1_pv    = 1'b0;
    chk("d1_busy_after_done", d1_busy, 0);
    tick();
    chk("d1_no_restart_busy", d1_busy, 0);
    chk("d1_no_restart_rd", d1_rd, 0);
    chk("d1_write_count", writes, 8);
    chk("d1_done_count", dones, 1);
    chk("d1_last_w_addr", last_w, 17);
    chk("d1_reads_left", ifm_q.size(), 0);
    chk("d1_writes_left", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
